// File: rtl/spi_read_pkg.sv
// Shared SPI mode-0 definitions: state encoding, bus idle levels and counter-width helpers.
// The SPI_RD_DUMMY_EN macro adds the DUMMY state to the read FSM encoding.
package spi_read_pkg;

   localparam logic SCLK_IDLE = 1'b0;
   localparam logic CS_ACTIVE = 1'b0;

`ifdef SPI_RD_DUMMY_EN
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_ADDR  = 3'd2,
      S_DUMMY = 3'd3,
      S_DATA  = 3'd4,
      S_HOLD  = 3'd5
   } state_e;
`else
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_ADDR  = 3'd2,
      S_DATA  = 3'd4,
      S_HOLD  = 3'd5
   } state_e;
`endif

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // Bits needed to count 0..n-1, never less than one.
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/spi_read_if.sv
// Local request/response bus of the SPI read master.
interface spi_read_if #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 8
);
   logic              start;
   logic [ADDR_W-1:0] addr;
   logic              busy;
   logic              done;
   logic [DATA_W-1:0] rdata;

   modport master (output start, addr, input busy, done, rdata);
   modport slave  (input start, addr, output busy, done, rdata);
endinterface

// File: rtl/spi_tick_gen.sv
// SCLK half-period generator: CLK_DIV cycles high, then CLK_DIV cycles low, restarting high on clear.
module spi_tick_gen
   import spi_read_pkg::*;
#(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   output logic rise_tick_o,
   output logic fall_tick_o,
   output logic bit_end_o,
   output logic sclk_o
);

   localparam int unsigned CW = cnt_w(CLK_DIV);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          phase_q, phase_d;
   logic          wrap;

   assign wrap = (cnt_q == CW'(CLK_DIV - 1));

   always_comb begin
      cnt_d   = cnt_q;
      phase_d = phase_q;
      if (clr_i) begin
         cnt_d   = '0;
         phase_d = 1'b0;
      end else if (wrap) begin
         cnt_d   = '0;
         phase_d = ~phase_q;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q   <= '0;
         phase_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
      end
   end

   // fall_tick marks the last high cycle, so a register loaded on it changes with the falling SCLK.
   assign rise_tick_o = ~clr_i & ~phase_q & (cnt_q == '0);
   assign fall_tick_o = ~clr_i & ~phase_q & wrap;
   assign bit_end_o   = ~clr_i &  phase_q & wrap;
   assign sclk_o      = clr_i ? SCLK_IDLE : ~phase_q;

endmodule

// File: rtl/spi_read.sv
// SPI mode-0 read master: sends an address on MOSI, then shifts in a data word from MISO.
// Define SPI_RD_DUMMY_EN to insert DUMMY_CYCLES idle SCLK cycles between address and data.
module spi_read
   import spi_read_pkg::*;
#(
   parameter int unsigned CLK_DIV      = 4,
   parameter int unsigned ADDR_W       = 8,
   parameter int unsigned DATA_W       = 8,
   parameter int unsigned CS_SETUP     = 2,
   parameter int unsigned DUMMY_CYCLES = 8
) (
   input  logic       clk_i,
   input  logic       rst_i,
   spi_read_if.slave  bus,
   output logic       sclk_o,
   output logic       cs_n_o,
   output logic       mosi_o,
   input  logic       miso_i
);

   localparam int unsigned BIT_W  = cnt_w(max3(ADDR_W, DATA_W, DUMMY_CYCLES));
   localparam int unsigned WAIT_W = cnt_w(CS_SETUP);

   state_e            state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [BIT_W-1:0]  bit_q, bit_d;
   logic [ADDR_W-1:0] tx_q, tx_d;
   logic [DATA_W-1:0] rx_q, rx_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              done_q, done_d;

   logic tick_clr, rise_tick, fall_tick, bit_end, tick_sclk;

   spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .clr_i       (tick_clr),
      .rise_tick_o (rise_tick),
      .fall_tick_o (fall_tick),
      .bit_end_o   (bit_end),
      .sclk_o      (tick_sclk)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         wait_q  <= '0;
         bit_q   <= '0;
         tx_q    <= '0;
         rx_q    <= '0;
         rdata_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         bit_q   <= bit_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         rdata_q <= rdata_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      bit_d   = bit_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      rdata_d = rdata_q;
      done_d  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d = S_SETUP;
               wait_d  = '0;
               tx_d    = bus.addr;
            end
         end
         S_SETUP: begin
            if (wait_q == WAIT_W'(CS_SETUP - 1)) begin
               state_d = S_ADDR;
               bit_d   = '0;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         S_ADDR: begin
            if (fall_tick) tx_d = tx_q << 1;
            if (bit_end) begin
               if (bit_q == BIT_W'(ADDR_W - 1)) begin
                  bit_d = '0;
`ifdef SPI_RD_DUMMY_EN
                  state_d = S_DUMMY;
`else
                  state_d = S_DATA;
`endif
               end else begin
                  bit_d = bit_q + BIT_W'(1);
               end
            end
         end
`ifdef SPI_RD_DUMMY_EN
         S_DUMMY: begin
            if (bit_end) begin
               if (bit_q == BIT_W'(DUMMY_CYCLES - 1)) begin
                  bit_d   = '0;
                  state_d = S_DATA;
               end else begin
                  bit_d = bit_q + BIT_W'(1);
               end
            end
         end
`endif
         S_DATA: begin
            if (rise_tick) rx_d = (rx_q << 1) | DATA_W'(miso_i);
            if (bit_end) begin
               if (bit_q == BIT_W'(DATA_W - 1)) begin
                  bit_d   = '0;
                  wait_d  = '0;
                  state_d = S_HOLD;
               end else begin
                  bit_d = bit_q + BIT_W'(1);
               end
            end
         end
         S_HOLD: begin
            if (wait_q == WAIT_W'(CS_SETUP - 1)) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
               rdata_d = rx_q;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      tick_clr  = 1'b1;
      bus.busy  = (state_q != S_IDLE);
      bus.done  = done_q;
      bus.rdata = rdata_q;
      cs_n_o    = (state_q == S_IDLE) ? ~CS_ACTIVE : CS_ACTIVE;
      mosi_o    = 1'b0;
      unique case (state_q)
         S_SETUP: mosi_o = tx_q[ADDR_W-1];
         S_ADDR: begin
            tick_clr = 1'b0;
            mosi_o   = tx_q[ADDR_W-1];
         end
`ifdef SPI_RD_DUMMY_EN
         S_DUMMY: tick_clr = 1'b0;
`endif
         S_DATA:  tick_clr = 1'b0;
         default: tick_clr = 1'b1;
      endcase
      sclk_o = tick_sclk;
   end

endmodule

// File: tb/tb_spi_read.sv
// Scoreboard bench for spi_read: acceptance model pushes expected transactions, a negedge monitor
// plays the SPI slave and checks MOSI bits, CS/busy windows, latency and received data.
module tb_spi_read;

   localparam int unsigned CLK_DIV      = 4;
   localparam int unsigned ADDR_W       = 8;
   localparam int unsigned DATA_W       = 8;
   localparam int unsigned CS_SETUP     = 2;
   localparam int unsigned DUMMY_CYCLES = 8;
`ifdef SPI_RD_DUMMY_EN
   localparam int unsigned DUM = DUMMY_CYCLES;
`else
   localparam int unsigned DUM = 0;
`endif
   localparam int unsigned NRISE = ADDR_W + DUM + DATA_W;
   localparam int          LAT   = 1 + 2 * CS_SETUP + 2 * CLK_DIV * NRISE;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic miso = 1'b0;
   logic sclk, cs_n, mosi;

   spi_read_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   spi_read #(
      .CLK_DIV      (CLK_DIV),
      .ADDR_W       (ADDR_W),
      .DATA_W       (DATA_W),
      .CS_SETUP     (CS_SETUP),
      .DUMMY_CYCLES (DUMMY_CYCLES)
   ) dut (
      .clk_i  (clk),
      .rst_i  (rst),
      .bus    (bus),
      .sclk_o (sclk),
      .cs_n_o (cs_n),
      .mosi_o (mosi),
      .miso_i (miso)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] word;
      int                due;
   } txn_t;

   txn_t              q[$];
   int                free_at = 0;
   logic [DATA_W-1:0] stim_word = '0;
   int                n_checks = 0;
   int                n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic finish_up();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   endtask

   // Monitor, SPI slave and acceptance model, in that order within each cycle.
   int   r = 0;
   logic prev_sclk = 1'b0, prev_cs = 1'b1, mosi_ref = 1'b0;
   always @(negedge clk) begin
      logic rise_e, fall_e, cs_fall, busy_exp;
      int   k;
      rise_e  = sclk && !prev_sclk;
      fall_e  = !sclk && prev_sclk;
      cs_fall = !cs_n && prev_cs;

      busy_exp = (q.size() > 0) && (cyc > q[0].due - LAT) && (cyc < q[0].due);
      check("busy", bus.busy, busy_exp);
      check("cs_n", cs_n, !busy_exp);
      if (!busy_exp) check("sclk_idle", sclk, 1'b0);

      if (cs_fall) begin
         r = 0;
         mosi_ref = mosi;
      end
      if (rise_e && q.size() > 0) begin
         check("mosi_bit", mosi, (r < ADDR_W) ? q[0].addr[ADDR_W-1-r] : 1'b0);
         check("mosi_hold", mosi, mosi_ref);
         r++;
      end
      if (fall_e) mosi_ref = mosi;

      if (bus.done) begin
         if (q.size() == 0) begin
            check("spurious_done", bus.done, 1'b0);
         end else begin
            check("rdata", bus.rdata, q[0].word);
            check("done_cycle", cyc, q[0].due);
            check("rise_count", r, NRISE);
            void'(q.pop_front());
         end
      end
      if (q.size() > 0 && cyc > q[0].due) begin
         check("done_missing", bus.done, 1'b1);
         void'(q.pop_front());
      end

      // Slave: present the bit for the next rise whenever SCLK falls or CS is asserted.
      if (cs_fall || fall_e) begin
         if (r < ADDR_W) miso = 1'($urandom_range(0, 1));
         else if (r < ADDR_W + DUM) miso = 1'b1;
         else if (r < NRISE && q.size() > 0) begin
            k = r - ADDR_W - DUM;
            miso = q[0].word[DATA_W-1-k];
         end else miso = 1'b0;
      end

      if (rst) begin
         q.delete();
         free_at = cyc + 1;
      end else if (bus.start && cyc >= free_at) begin
         q.push_back('{addr: bus.addr, word: stim_word, due: cyc + LAT});
         free_at = cyc + LAT;
      end

      prev_sclk = sclk;
      prev_cs   = cs_n;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic go(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] w, output int n);
      int guard = 0;
      while (cyc < free_at) begin
         tick();
         guard++;
         if (guard > 4 * LAT) begin
            check("go_timeout", guard, 0);
            finish_up();
         end
      end
      stim_word = w;
      bus.addr  = a;
      bus.start = 1'b1;
      n = cyc;
      tick();
      bus.start = 1'b0;
      bus.addr  = ADDR_W'($urandom);
   endtask

   task automatic wait_idle();
      int guard = 0;
      while (q.size() > 0) begin
         tick();
         guard++;
         if (guard > 4 * LAT) begin
            check("idle_timeout", q.size(), 0);
            finish_up();
         end
      end
      tick();
   endtask

   initial begin
      int n, bad, dones;
      logic [DATA_W-1:0] words [3];
      words[0] = DATA_W'('h81);
      words[1] = DATA_W'('hFF);
      words[2] = DATA_W'('h00);
      bus.start = 1'b0;
      bus.addr  = '0;

      // Reset state, with start asserted during reset.
      repeat (3) tick();
      bus.start = 1'b1;
      tick();
      check("rst_busy", bus.busy, 1'b0);
      check("rst_done", bus.done, 1'b0);
      check("rst_rdata", bus.rdata, 0);
      check("rst_sclk", sclk, 1'b0);
      check("rst_cs_n", cs_n, 1'b1);
      check("rst_mosi", mosi, 1'b0);
      bus.start = 1'b0;
      rst = 1'b0;
      tick();

      go(ADDR_W'('h9A), DATA_W'('h5C), n);
      wait_idle();
      check("t1_rdata", bus.rdata, DATA_W'('h5C));

      for (int unsigned i = 0; i < 3; i++) begin
         go(ADDR_W'($urandom), words[i], n);
         wait_idle();
         check("t2_rdata", bus.rdata, words[i]);
      end

      // start held high: back-to-back transactions separated by one CS-high cycle.
      stim_word = DATA_W'($urandom);
      bus.addr  = ADDR_W'($urandom);
      bus.start = 1'b1;
      n = cyc;
      bad = 0;
      dones = 0;
      for (int i = 1; i < 200; i++) begin
         tick();
         if (cs_n !== ((cyc - n) % LAT == 0)) bad++;
         if (bus.done) dones++;
      end
      bus.start = 1'b0;
      check("t3_cs_gap", bad, 0);
      check("t3_dones", dones, 199 / LAT);
      wait_idle();

      // start pulsed while busy is ignored.
      go(ADDR_W'($urandom), DATA_W'($urandom_range(1, 255)), n);
      while (cyc < n + 20) tick();
      check("t4_busy", bus.busy, 1'b1);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      wait_idle();

      // Reset mid-transaction discards it, then a clean read follows.
      go(ADDR_W'($urandom), DATA_W'($urandom), n);
      while (cyc < n + 60) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t5_cs_n", cs_n, 1'b1);
      check("t5_sclk", sclk, 1'b0);
      check("t5_busy", bus.busy, 1'b0);
      check("t5_rdata", bus.rdata, 0);
      check("t5_done", bus.done, 1'b0);
      go(ADDR_W'($urandom), DATA_W'('hA5), n);
      wait_idle();
      check("t5_rdata_after", bus.rdata, DATA_W'('hA5));

      go(ADDR_W'($urandom), DATA_W'('h3C), n);
      wait_idle();
      check("t6_rdata", bus.rdata, DATA_W'('h3C));

      // Random reads with random gaps, including back-to-back.
      for (int unsigned i = 0; i < 12; i++) begin
         repeat ($urandom_range(0, 3)) tick();
         go(ADDR_W'($urandom), DATA_W'($urandom), n);
      end
      wait_idle();

      finish_up();
   end

endmodule
